// File: rtl/pf_lanectrl_pause_gen.sv
// ---------------------------------------------------------------------------
// pf_lanectrl_pause_gen
//
// Lane-control clock-pause sequencer wrapped around a delay-code update in a
// DDR PHY lane. A training/calibration requester raises UPDATE_REQ with a new
// delay code. The block then:
//   1. latches the code and raises HS_IO_CLK_PAUSE (PRE phase);
//   2. pulses DELAY_LOAD while the lane clock is paused (LOAD phase);
//   3. keeps the pause high for guard cycles (POST phase);
//   4. drops the pause, pulses UPDATE_ACK and enforces a minimum pause-low
//      gap (GAP phase) before the next request may be accepted.
//
// Ports
//   CLK              in   lane control clock, rising edge only
//   RESET            in   synchronous, active-high reset
//   UPDATE_REQ       in   level request, held until UPDATE_ACK
//   UPDATE_CODE      in   new delay code, valid while UPDATE_REQ is high
//   UPDATE_ACK       out  one-cycle pulse in the first pause-low cycle
//   BUSY             out  high whenever the sequencer is not idle
//   HS_IO_CLK_PAUSE  out  registered pause request to the pause synchroniser
//   DELAY_LOAD       out  registered load strobe to the lane delay lines
//   DELAY_CODE       out  registered delay code, changes only on acceptance
//
// Every output comes straight from a flop so the downstream synchroniser
// never sees a combinational glitch.
// ---------------------------------------------------------------------------
module pf_lanectrl_pause_gen #(
  parameter int PRE_CYCLES  = 2,
  parameter int LOAD_CYCLES = 1,
  parameter int POST_CYCLES = 3,
  parameter int GAP_CYCLES  = 2,
  parameter int CODE_WIDTH  = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  UPDATE_REQ,
  input  logic [CODE_WIDTH-1:0] UPDATE_CODE,
  output logic                  UPDATE_ACK,
  output logic                  BUSY,
  output logic                  HS_IO_CLK_PAUSE,
  output logic                  DELAY_LOAD,
  output logic [CODE_WIDTH-1:0] DELAY_CODE
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_LOAD = 3'd2,
    ST_POST = 3'd3,
    ST_GAP  = 3'd4
  } state_e;

  // Counter reload values: a timed state lasting N cycles is entered with
  // N-1 and exits on the cycle the counter reads zero.
  localparam logic [7:0] PRE_INIT  = 8'(PRE_CYCLES  - 1);
  localparam logic [7:0] LOAD_INIT = 8'(LOAD_CYCLES - 1);
  localparam logic [7:0] POST_INIT = 8'(POST_CYCLES - 1);
  localparam logic [7:0] GAP_INIT  = 8'(GAP_CYCLES  - 1);

  state_e                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  pause_q, pause_d;
  logic                  load_q, load_d;
  logic                  ack_q, ack_d;
  logic                  busy_q, busy_d;
  logic [CODE_WIDTH-1:0] code_q, code_d;
  logic                  accept_s;
  logic                  cnt_zero_s;

  assign cnt_zero_s = (cnt_q == 8'd0);

  // Next-state and next-output computation for the sequencer
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pause_d  = pause_q;
    load_d   = load_q;
    ack_d    = 1'b0;
    busy_d   = busy_q;
    code_d   = code_q;
    accept_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (UPDATE_REQ) begin
          accept_s = 1'b1;
        end else begin
          pause_d = 1'b0;
          load_d  = 1'b0;
          busy_d  = 1'b0;
        end
      end

      ST_PRE: begin
        if (cnt_zero_s) begin
          state_d = ST_LOAD;
          cnt_d   = LOAD_INIT;
          load_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      ST_LOAD: begin
        if (cnt_zero_s) begin
          state_d = ST_POST;
          cnt_d   = POST_INIT;
          load_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      ST_POST: begin
        if (cnt_zero_s) begin
          state_d = ST_GAP;
          cnt_d   = GAP_INIT;
          pause_d = 1'b0;
          ack_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      ST_GAP: begin
        // The edge that closes the last gap cycle doubles as the idle sample
        // point, so a held request restarts after exactly GAP_CYCLES of
        // pause-low instead of GAP_CYCLES+1.
        if (cnt_zero_s) begin
          if (UPDATE_REQ) begin
            accept_s = 1'b1;
          end else begin
            state_d = ST_IDLE;
            cnt_d   = 8'd0;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end

      default: begin
        // Unreachable encoding: fall back to a quiet idle.
        state_d = ST_IDLE;
        cnt_d   = 8'd0;
        pause_d = 1'b0;
        load_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    // Acceptance: capture the code and open the pause window.
    if (accept_s) begin
      state_d = ST_PRE;
      cnt_d   = PRE_INIT;
      pause_d = 1'b1;
      load_d  = 1'b0;
      busy_d  = 1'b1;
      code_d  = UPDATE_CODE;
    end else begin
      code_d = code_q;
    end
  end

  // Sequencer state and registered outputs; RESET wins over any request
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      pause_q <= 1'b0;
      load_q  <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pause_q <= pause_d;
      load_q  <= load_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      code_q  <= code_d;
    end
  end

  assign UPDATE_ACK      = ack_q;
  assign BUSY            = busy_q;
  assign HS_IO_CLK_PAUSE = pause_q;
  assign DELAY_LOAD      = load_q;
  assign DELAY_CODE      = code_q;

endmodule

// File: tb/tb_pf_lanectrl_pause_gen.sv
// ---------------------------------------------------------------------------
// Bench for pf_lanectrl_pause_gen. Two instances: one with default timing,
// one with every phase set to a single cycle. Expected per-cycle outputs are
// derived from the sequence timing formulas and queued as stimulus is
// planned; each clock they are popped and compared against the DUT.
// ---------------------------------------------------------------------------
module tb_pf_lanectrl_pause_gen;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       req_a, req_b;
  logic [7:0] code_a, code_b;

  logic       a_ack, a_busy, a_pause, a_load;
  logic [7:0] a_code;
  logic       b_ack, b_busy, b_pause, b_load;
  logic [7:0] b_code;

  pf_lanectrl_pause_gen dut_a (
    .CLK(clk), .RESET(rst), .UPDATE_REQ(req_a), .UPDATE_CODE(code_a),
    .UPDATE_ACK(a_ack), .BUSY(a_busy), .HS_IO_CLK_PAUSE(a_pause),
    .DELAY_LOAD(a_load), .DELAY_CODE(a_code)
  );

  pf_lanectrl_pause_gen #(
    .PRE_CYCLES(1), .LOAD_CYCLES(1), .POST_CYCLES(1), .GAP_CYCLES(1), .CODE_WIDTH(8)
  ) dut_b (
    .CLK(clk), .RESET(rst), .UPDATE_REQ(req_b), .UPDATE_CODE(code_b),
    .UPDATE_ACK(b_ack), .BUSY(b_busy), .HS_IO_CLK_PAUSE(b_pause),
    .DELAY_LOAD(b_load), .DELAY_CODE(b_code)
  );

  typedef struct packed {
    logic       pause;
    logic       load;
    logic       ack;
    logic       busy;
    logic [7:0] code;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   sel    = 0;

  // Queue the first ncyc cycles of one sequence, cycle 1 = acceptance cycle.
  task automatic push_seq(input logic [7:0] code, input int p, input int l,
                          input int o, input int g, input int ncyc);
    exp_t e;
    for (int c = 1; c <= p + l + o + g; c++) begin
      if (c <= ncyc) begin
        e.pause = (c <= p + l + o);
        e.load  = (c > p) && (c <= p + l);
        e.ack   = (c == p + l + o + 1);
        e.busy  = 1'b1;
        e.code  = code;
        sb.push_back(e);
      end
    end
  endtask

  task automatic push_idle(input int n, input logic [7:0] code);
    exp_t e;
    e.pause = 1'b0;
    e.load  = 1'b0;
    e.ack   = 1'b0;
    e.busy  = 1'b0;
    e.code  = code;
    for (int i = 0; i < n; i++) sb.push_back(e);
  endtask

  task automatic chk(input string tag, input int cyc, input logic [7:0] obs,
                     input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s cyc%0d: observed %h expected %h", tag, cyc, obs, expv);
    end
  endtask

  // Advance n clocks, comparing the DUT selected by sel after each edge.
  task automatic step(input int n, input string tag);
    exp_t e;
    exp_t o;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (sel == 0) o = '{a_pause, a_load, a_ack, a_busy, a_code};
      else          o = '{b_pause, b_load, b_ack, b_busy, b_code};
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL %s cyc%0d: observed empty scoreboard expected entry", tag, i);
      end else begin
        e = sb.pop_front();
        chk({tag, ".pause"}, i, {7'd0, o.pause}, {7'd0, e.pause});
        chk({tag, ".load"},  i, {7'd0, o.load},  {7'd0, e.load});
        chk({tag, ".ack"},   i, {7'd0, o.ack},   {7'd0, e.ack});
        chk({tag, ".busy"},  i, {7'd0, o.busy},  {7'd0, e.busy});
        chk({tag, ".code"},  i, o.code, e.code);
      end
    end
  endtask

  initial begin
    rst    = 1'b1;
    req_a  = 1'b1;
    code_a = 8'h77;
    req_b  = 1'b0;
    code_b = 8'h00;

    // Reset held 3 cycles with REQ high: everything stays zero.
    push_idle(3, 8'h00);
    step(3, "reset");

    // First edge after reset release accepts the pending request.
    rst = 1'b0;
    push_seq(8'h77, 2, 1, 3, 2, 8);
    push_idle(2, 8'h77);
    step(1, "rst_rel");
    req_a = 1'b0;
    step(9, "rst_rel");

    // Single update 0xA5; input code changes mid-sequence must not leak out.
    req_a  = 1'b1;
    code_a = 8'hA5;
    push_seq(8'hA5, 2, 1, 3, 2, 8);
    push_idle(3, 8'hA5);
    step(1, "single");
    code_a = 8'hFF;
    step(6, "single");
    req_a = 1'b0;
    step(4, "single");

    // Held REQ: two back-to-back sequences separated by exactly 2 low cycles.
    req_a  = 1'b1;
    code_a = 8'h3C;
    push_seq(8'h3C, 2, 1, 3, 2, 8);
    push_seq(8'h3C, 2, 1, 3, 2, 8);
    push_idle(2, 8'h3C);
    step(16, "held");
    req_a = 1'b0;
    step(2, "held");

    // REQ dropped during PRE: the sequence still runs to completion.
    req_a  = 1'b1;
    code_a = 8'h5A;
    push_seq(8'h5A, 2, 1, 3, 2, 8);
    push_idle(2, 8'h5A);
    step(1, "pre_drop");
    req_a = 1'b0;
    step(9, "pre_drop");

    // RESET during LOAD: outputs clear at once, no ACK afterwards.
    req_a  = 1'b1;
    code_a = 8'hC3;
    push_seq(8'hC3, 2, 1, 3, 2, 3);
    push_idle(3, 8'h00);
    step(1, "rst_load");
    req_a = 1'b0;
    step(2, "rst_load");
    rst = 1'b1;
    step(1, "rst_load");
    rst = 1'b0;
    step(2, "rst_load");

    // All-ones timing instance with REQ held: re-acceptance in cycle 5.
    sel    = 1;
    req_b  = 1'b1;
    code_b = 8'h81;
    push_seq(8'h81, 1, 1, 1, 1, 4);
    push_seq(8'h81, 1, 1, 1, 1, 4);
    push_idle(2, 8'h81);
    step(7, "min");
    req_b = 1'b0;
    step(3, "min");

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_drain: observed %0d leftover expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
